dm_access_unit: RTL and testbench

Data-memory responder for the RV32 core. It services the load/store request (DM_enable, DM_write, effective address) that EX raises, and drives the single-port word-wide data SRAM. It stalls the pipeline until the access completes, performs byte-lane steering for stores and sign/zero extension for loads, and returns load data to MEM/WB.

---
 rtl/dm_pkg.sv | 38 +++
 rtl/dm_lane_align.sv | 64 ++++++
 rtl/dm_access_unit.sv | 163 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit.
//   dm_state_t     - access FSM states
//   F3_*           - load/store size encodings carried in funct3
//   OP_LOAD/STORE  - major opcodes that raise a data-memory request
//   dm_misaligned  - returns 1 when a size/offset pair cannot be serviced
package dm_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4
    } dm_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b000_0011;
    localparam logic [6:0] OP_STORE = 7'b010_0011;

    // Unknown sizes are rejected the same way as misaligned offsets.
    function automatic logic dm_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the data-memory access unit (purely combinational).
//   i_funct3     - access size / signedness
//   i_addr_lo    - byte offset within the word
//   i_wdata      - raw store data (rs2)
//   i_rdata_raw  - word read from the SRAM
//   o_sram_di    - store data replicated onto every lane
//   o_sram_web   - active-low byte write enables for the addressed lanes
//   o_load_data  - selected lane(s), sign- or zero-extended
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_raw,
    output logic [31:0] o_sram_di,
    output logic [3:0]  o_sram_web,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store path: data is replicated so the enables alone pick the lane.
    always_comb begin
        o_sram_di  = i_wdata;
        o_sram_web = 4'hF;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_sram_di  = {4{i_wdata[7:0]}};
                o_sram_web = ~(4'b0001 << i_addr_lo);
            end
            F3_H, F3_HU: begin
                o_sram_di  = {2{i_wdata[15:0]}};
                o_sram_web = i_addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            F3_W: begin
                o_sram_di  = i_wdata;
                o_sram_web = 4'b0000;
            end
            default: ;
        endcase
    end

    // Load path.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata_raw[7:0];
            2'd1:    w_byte = i_rdata_raw[15:8];
            2'd2:    w_byte = i_rdata_raw[23:16];
            default: w_byte = i_rdata_raw[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_rdata_raw;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory responder: accepts one load/store from EX, stalls the pipeline
// while it drives the single-port word SRAM, and returns extended load data.
//   i_clk, i_rst               - clock, synchronous active-low reset
//   i_req_*                    - request from EX (enable, write, addr, wdata, funct3)
//   o_stall                    - hold the pipeline
//   o_rdata_valid, o_rdata     - one-cycle load completion and its result
//   o_misalign                 - one-cycle rejection of an illegal access
//   o_sram_cs/oe/web/addr/di   - SRAM control, address and write data
//   i_sram_do                  - SRAM read data
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_enable,
    input  logic              i_req_write,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [2:0]        i_req_funct3,
    output logic              o_stall,
    output logic              o_rdata_valid,
    output logic [31:0]       o_rdata,
    output logic              o_misalign,
    output logic              o_sram_cs,
    output logic              o_sram_oe,
    output logic [3:0]        o_sram_web,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_di,
    input  logic [31:0]       i_sram_do
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    dm_state_t         r_state;
    dm_state_t         w_state_d;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic              r_write;
    logic              r_mis;
    logic [1:0]        r_lat_cnt;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_req_mis;
    logic              w_lat_last;
    logic [31:0]       w_sram_di;
    logic [3:0]        w_sram_web;
    logic [31:0]       w_load_data;
    logic              w_unused_addr;

    assign w_unused_addr = ^i_req_addr[31:ADDR_W+2];
    assign w_accept      = (r_state == StIdle) && i_req_enable;
    assign w_req_mis     = dm_misaligned(i_req_funct3, i_req_addr[1:0]);
    assign w_lat_last    = (r_lat_cnt == LAT_LAST);

    dm_lane_align u_lane_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata_raw (i_sram_do),
        .o_sram_di   (w_sram_di),
        .o_sram_web  (w_sram_web),
        .o_load_data (w_load_data)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic. DONE always returns to IDLE: a request still seen
    // there is the one just completed, held by the stalled pipeline.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_req_enable) begin
                    if (w_req_mis)        w_state_d = StDone;
                    else if (i_req_write) w_state_d = StWrite;
                    else                  w_state_d = StRead;
                end
            end
            StWrite: w_state_d = StDone;
            StRead:  w_state_d = StWait;
            StWait:  if (w_lat_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Request capture, read-latency counter and load result.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            r_write   <= 1'b0;
            r_mis     <= 1'b0;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= i_req_addr[ADDR_W+1:0];
                r_wdata  <= i_req_wdata;
                r_funct3 <= i_req_funct3;
                r_write  <= i_req_write;
                r_mis    <= w_req_mis;
            end
            if (r_state == StRead) begin
                r_lat_cnt <= '0;
            end else if (r_state == StWait) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end
            if ((r_state == StWait) && w_lat_last) begin
                r_rdata <= w_load_data;
            end
        end
    end

    // Outputs.
    always_comb begin
        o_stall       = 1'b0;
        o_rdata_valid = 1'b0;
        o_misalign    = 1'b0;
        o_sram_cs     = 1'b0;
        o_sram_oe     = 1'b0;
        o_sram_web    = 4'hF;
        o_sram_di     = '0;
        unique case (r_state)
            StIdle: o_stall = i_req_enable;
            StWrite: begin
                o_stall    = 1'b1;
                o_sram_cs  = 1'b1;
                o_sram_web = w_sram_web;
                o_sram_di  = w_sram_di;
            end
            StRead: begin
                o_stall   = 1'b1;
                o_sram_cs = 1'b1;
                o_sram_oe = 1'b1;
            end
            StWait: o_stall = 1'b1;
            StDone: begin
                o_rdata_valid = !r_write && !r_mis;
                o_misalign    = r_mis;
            end
            default: ;
        endcase
    end

    // A rejected access reports zero without disturbing the held result.
    assign o_rdata     = ((r_state == StDone) && r_mis) ? 32'h0 : r_rdata;
    assign o_sram_addr = r_addr[ADDR_W+1:2];

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_enable;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              stall;
    logic              rdata_valid;
    logic [31:0]       rdata;
    logic              misalign;
    logic              sram_cs;
    logic              sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_di;
    logic [31:0]       sram_do = 32'h0;

    logic [31:0] mem [0:15] = '{default: 32'h0};

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    int vld_count = 0;

    // Per-request observations.
    int          s_stall;
    int          s_cs;
    logic        s_done;
    logic        s_mis;
    logic        s_vld;
    logic [31:0] s_rd;
    logic [3:0]  s_web;
    logic [31:0] s_di;
    logic [31:0] s_addr;

    always #5 clk = ~clk;

    dm_access_unit #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_enable  (req_enable),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_funct3  (req_funct3),
        .o_stall       (stall),
        .o_rdata_valid (rdata_valid),
        .o_rdata       (rdata),
        .o_misalign    (misalign),
        .o_sram_cs     (sram_cs),
        .o_sram_oe     (sram_oe),
        .o_sram_web    (sram_web),
        .o_sram_addr   (sram_addr),
        .o_sram_di     (sram_di),
        .i_sram_do     (sram_do)
    );

    // SRAM model: read data registered at the READ edge and held.
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_oe) begin
                sram_do <= mem[sram_addr[3:0]];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_web[i]) mem[sram_addr[3:0]][8*i +: 8] <= sram_di[8*i +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sram_cs && !sram_oe) wr_count++;
        if (rdata_valid) vld_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request just after a posedge, hold it while stalled, release
    // it after the DONE edge. Samples on negedges.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f);
        req_enable = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        s_stall = 0;
        s_cs    = 0;
        s_done  = 1'b0;
        s_mis   = 1'b0;
        s_vld   = 1'b0;
        s_rd    = 32'h0;
        s_web   = 4'hF;
        s_di    = 32'h0;
        s_addr  = 32'h0;
        for (int i = 0; i < 20 && !s_done; i++) begin
            @(negedge clk);
            if (sram_cs) begin
                s_cs++;
                if (!sram_oe) begin
                    s_web  = sram_web;
                    s_di   = sram_di;
                    s_addr = 32'(sram_addr);
                end
            end
            if (stall) begin
                s_stall++;
            end else begin
                s_done = 1'b1;
                s_mis  = misalign;
                s_vld  = rdata_valid;
                s_rd   = rdata;
            end
        end
        check_eq("req_completes", 32'(s_done), 32'd1);
        @(posedge clk);
        #1;
        req_enable = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] exp);
        int v0;
        v0 = vld_count;
        run_req(1'b0, a, 32'h0, f);
        check_eq({tag, "_rdata"}, s_rd, exp);
        check_eq({tag, "_valid"}, 32'(s_vld), 32'd1);
        check_eq({tag, "_pulses"}, 32'(vld_count - v0), 32'd1);
    endtask

    initial begin
        int w0;
        int v0;
        rst        = 1'b0;
        req_enable = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_valid", 32'(rdata_valid), 32'd0);
        check_eq("rst_mis", 32'(misalign), 32'd0);
        check_eq("rst_cs", 32'(sram_cs), 32'd0);
        check_eq("rst_oe", 32'(sram_oe), 32'd0);
        check_eq("rst_web", 32'(sram_web), 32'hF);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_addr", 32'(sram_addr), 32'h0);
        check_eq("rst_di", sram_di, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // SW 0x10
        run_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        check_eq("sw_stall", 32'(s_stall), 32'd2);
        check_eq("sw_cs", 32'(s_cs), 32'd1);
        check_eq("sw_web", 32'(s_web), 32'h0);
        check_eq("sw_di", s_di, 32'hDEADBEEF);
        check_eq("sw_addr", s_addr, 32'd4);
        check_eq("sw_flags", {30'h0, s_mis, s_vld}, 32'h0);

        // SB 0x13
        run_req(1'b1, 32'h13, 32'h000000A5, 3'b000);
        check_eq("sb_web", 32'(s_web), 32'h7);
        check_eq("sb_di", s_di, 32'hA5A5A5A5);
        check_eq("sb_stall", 32'(s_stall), 32'd2);

        // Loads
        v0 = vld_count;
        run_req(1'b0, 32'h10, 32'h0, 3'b010);
        check_eq("lw_rdata", s_rd, 32'hA5ADBEEF);
        check_eq("lw_valid", 32'(s_vld), 32'd1);
        check_eq("lw_pulses", 32'(vld_count - v0), 32'd1);
        check_eq("lw_stall", 32'(s_stall), 32'd5);
        check_eq("lw_cs", 32'(s_cs), 32'd1);
        do_load("lb13", 32'h13, 3'b000, 32'hFFFFFFA5);
        do_load("lbu13", 32'h13, 3'b100, 32'h000000A5);
        do_load("lh12", 32'h12, 3'b001, 32'hFFFFA5AD);
        do_load("lb10", 32'h10, 3'b000, 32'hFFFFFFEF);

        // SH upper half of word 5
        run_req(1'b1, 32'h16, 32'hCAFE1234, 3'b001);
        check_eq("sh_web", 32'(s_web), 32'h3);
        check_eq("sh_di", s_di, 32'h12341234);
        check_eq("sh_addr", s_addr, 32'd5);
        do_load("lw14", 32'h14, 3'b010, 32'h12340000);
        do_load("lhu12", 32'h12, 3'b101, 32'h0000A5AD);
        check_eq("lhu12_stall", 32'(s_stall), 32'd5);

        // Misaligned / illegal
        run_req(1'b0, 32'h12, 32'h0, 3'b010);
        check_eq("mis_lw_flag", 32'(s_mis), 32'd1);
        check_eq("mis_lw_valid", 32'(s_vld), 32'd0);
        check_eq("mis_lw_rdata", s_rd, 32'h0);
        check_eq("mis_lw_cs", 32'(s_cs), 32'd0);
        check_eq("mis_lw_stall", 32'(s_stall), 32'd1);
        w0 = wr_count;
        run_req(1'b1, 32'h11, 32'hFFFFFFFF, 3'b001);
        check_eq("mis_sh_flag", 32'(s_mis), 32'd1);
        check_eq("mis_sh_nowrite", 32'(wr_count - w0), 32'd0);
        run_req(1'b0, 32'h10, 32'h0, 3'b011);
        check_eq("ill_f3_flag", 32'(s_mis), 32'd1);
        check_eq("ill_f3_cs", 32'(s_cs), 32'd0);
        do_load("post_mis_lw", 32'h14, 3'b010, 32'h12340000);

        // Reset during WAIT of a load
        v0 = vld_count;
        req_enable = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_enable = 1'b0;
        @(negedge clk);
        check_eq("rstmid_stall", 32'(stall), 32'd0);
        check_eq("rstmid_cs", 32'(sram_cs), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("rstmid_novalid", 32'(vld_count - v0), 32'd0);
        @(posedge clk);
        #1;
        do_load("rstmid_lw", 32'h10, 3'b010, 32'hA5ADBEEF);

        // Back-to-back stores
        w0 = wr_count;
        run_req(1'b1, 32'h20, 32'h11111111, 3'b010);
        check_eq("b2b_first_cs", 32'(s_cs), 32'd1);
        run_req(1'b1, 32'h24, 32'h22222222, 3'b010);
        check_eq("b2b_second_cs", 32'(s_cs), 32'd1);
        check_eq("b2b_writes", 32'(wr_count - w0), 32'd2);
        do_load("b2b_lw20", 32'h20, 3'b010, 32'h11111111);
        do_load("b2b_lw24", 32'h24, 3'b010, 32'h22222222);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
